aes_round_sequencer: RTL

Top-level round controller for the AES encryption datapath. It sequences the AddRoundKey, ByteSub_ShiftRow and MixColumn sub-blocks through the full round schedule over their ap_start/ap_done handshakes, and drives the round number `n` into AddRoundKey. It also drives the `statemt` memory-port select so exactly one sub-block owns the shared state memory at a time. A watchdog flags a sub-block that never completes.

---
 rtl/aes_round_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/aes_round_sequencer.sv
// Purpose : AES round controller. It walks AddRoundKey / ByteSub_ShiftRow / MixColumn
//           through NR rounds over their ap_start/ap_done handshakes and muxes statemt ownership.
// Latency : ark_start rises 1 cycle after ap_start. Stage boundaries add no cycles.
//           ap_done comes 1 + sum(stage lengths) cycles after ap_start.
// Backpressure: each *_start is held high until the matching done is sampled. A stage that
//           runs TIMEOUT cycles without done is aborted, with err set.
// Ports   : ap_clk/ap_rst (sync, active-high), ap_start/ap_done/ap_idle/ap_ready (block
//           handshake), err (sticky timeout), ark_start/ark_n/ark_done, bsr_start/bsr_done,
//           mix_start/mix_done (sub-block handshakes), mem_sel (0 ARK, 1 BSR, 2 MIX, 3 none).
module aes_round_sequencer #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic       ap_clk,
  input  logic       ap_rst,
  input  logic       ap_start,
  output logic       ap_done,
  output logic       ap_idle,
  output logic       ap_ready,
  output logic       err,
  output logic       ark_start,
  output logic [5:0] ark_n,
  input  logic       ark_done,
  output logic       bsr_start,
  input  logic       bsr_done,
  output logic       mix_start,
  input  logic       mix_done,
  output logic [1:0] mem_sel
);

  localparam int             WDW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);
  localparam logic [3:0]     RND_LAST  = 4'(NR);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARK  = 3'd1;
  localparam logic [2:0] S_BSR  = 3'd2;
  localparam logic [2:0] S_MIX  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [3:0]     rnd_q;
  logic [WDW-1:0] wd_q;
  logic           err_q;

  logic in_stage;
  logic stage_done;
  logic wd_expired;
  logic accept;

  // Only the done input of the sub-block that currently owns the stage matters.
  always_comb begin
    in_stage   = (state_q == S_ARK) || (state_q == S_BSR) || (state_q == S_MIX);
    stage_done = ((state_q == S_ARK) && ark_done) ||
                 ((state_q == S_BSR) && bsr_done) ||
                 ((state_q == S_MIX) && mix_done);
    // A done that arrives in the last allowed cycle still counts as success.
    wd_expired = in_stage && (wd_q == WD_LAST) && !stage_done;
    accept     = (state_q == S_IDLE) && ap_start;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ap_start) state_d = S_ARK;
      S_ARK: begin
        if (ark_done)        state_d = (rnd_q == RND_LAST) ? S_FIN : S_BSR;
        else if (wd_expired) state_d = S_FIN;
      end
      S_BSR: begin
        // The final round has no MixColumn; it goes straight to the last AddRoundKey.
        if (bsr_done)        state_d = (rnd_q == RND_LAST) ? S_ARK : S_MIX;
        else if (wd_expired) state_d = S_FIN;
      end
      S_MIX: begin
        if (mix_done)        state_d = S_ARK;
        else if (wd_expired) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      // Every stage transition is also a state change, so this restarts the watchdog per stage.
      if (state_d != state_q) wd_q <= '0;
      else if (in_stage)      wd_q <= wd_q + 1'b1;

      if (accept)
        rnd_q <= 4'd0;
      else if ((state_q == S_ARK) && ark_done && (rnd_q != RND_LAST))
        rnd_q <= rnd_q + 4'd1;

      if (accept)          err_q <= 1'b0;
      else if (wd_expired) err_q <= 1'b1;
    end
  end

  always_comb begin
    ark_start = (state_q == S_ARK);
    bsr_start = (state_q == S_BSR);
    mix_start = (state_q == S_MIX);
    ap_done   = (state_q == S_FIN);
    ap_ready  = (state_q == S_FIN);
    ap_idle   = (state_q == S_IDLE) && !ap_start;
    err       = err_q;
    ark_n     = {2'b00, rnd_q};
    case (state_q)
      S_ARK:   mem_sel = 2'd0;
      S_BSR:   mem_sel = 2'd1;
      S_MIX:   mem_sel = 2'd2;
      default: mem_sel = 2'd3;
    endcase
  end

endmodule
